// File: rtl/dstack.sv
// Data-stack register file: holds the stack entries, applies one movement or
// rotate per non-stalled cycle, tracks occupancy and latches sticky faults.
module dstack #(
    parameter int unsigned WORD_WIDTH  = 32,
    parameter int unsigned STACK_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic [1:0]            movement,
    input  logic [WORD_WIDTH-1:0] next_top,
    input  logic                  rotate,
    input  logic [4:0]            rotate_addr,
    output logic [WORD_WIDTH-1:0] top,
    output logic [WORD_WIDTH-1:0] second,
    output logic [WORD_WIDTH-1:0] third,
    output logic [WORD_WIDTH-1:0] rotate_value,
    output logic [5:0]            depth,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [5:0] DepthMax = 6'(STACK_DEPTH);
    localparam logic [4:0] LastIdx  = 5'(STACK_DEPTH - 1);

    logic [WORD_WIDTH-1:0] e_q [STACK_DEPTH];
    logic [WORD_WIDTH-1:0] e_d [STACK_DEPTH];
    logic [5:0]            depth_q, depth_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [4:0]            rot_n;

    // Illegal rotate indices beyond the array are clamped to the bottom entry.
    always_comb begin
        rot_n = (int'(rotate_addr) >= int'(STACK_DEPTH)) ? LastIdx : rotate_addr;
    end

    // Next-state for entries, occupancy and fault flags.
    always_comb begin
        e_d         = e_q;
        depth_d     = depth_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (!stall) begin
            e_d[0] = next_top;
            unique case (movement)
                2'b00: begin
                    if (rotate) begin
                        // Entries 0..n-1 sink by one; the caller supplies entry n as next_top.
                        for (int i = 1; i < int'(STACK_DEPTH); i++) begin
                            if (i <= int'(rot_n)) e_d[i] = e_q[i-1];
                        end
                        if ({1'b0, rotate_addr} >= depth_q) underflow_d = 1'b1;
                    end else if (depth_q == 6'd0) begin
                        depth_d = 6'd1;
                    end
                end
                2'b01: begin
                    for (int i = 1; i < int'(STACK_DEPTH); i++) e_d[i] = e_q[i-1];
                    if (depth_q == DepthMax) overflow_d = 1'b1;
                    else                     depth_d    = depth_q + 6'd1;
                end
                2'b10: begin
                    for (int i = 1; i < int'(STACK_DEPTH) - 1; i++) e_d[i] = e_q[i+1];
                    e_d[STACK_DEPTH-1] = '0;
                    if (depth_q >= 6'd2) begin
                        depth_d = depth_q - 6'd1;
                    end else if (depth_q == 6'd0) begin
                        underflow_d = 1'b1;
                    end
                end
                2'b11: begin
                    for (int i = 1; i < int'(STACK_DEPTH) - 2; i++) e_d[i] = e_q[i+2];
                    e_d[STACK_DEPTH-2] = '0;
                    e_d[STACK_DEPTH-1] = '0;
                    if (depth_q >= 6'd3) begin
                        depth_d = depth_q - 6'd2;
                    end else begin
                        depth_d     = (depth_q == 6'd0) ? 6'd0 : depth_q - 6'd1;
                        underflow_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers with synchronous reset taking priority over stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(STACK_DEPTH); i++) e_q[i] <= '0;
            depth_q     <= 6'd0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(STACK_DEPTH); i++) e_q[i] <= e_d[i];
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Register-driven outputs plus the zero-latency rotate/copy read port.
    always_comb begin
        top          = e_q[0];
        second       = e_q[1];
        third        = e_q[2];
        rotate_value = (int'(rotate_addr) < int'(STACK_DEPTH)) ? e_q[rotate_addr] : '0;
        depth        = depth_q;
        empty        = (depth_q == 6'd0);
        full         = (depth_q == DepthMax);
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

endmodule

// File: tb/tb_dstack.sv
// Directed bench for dstack: pushes, pops, overflow/underflow, rotate, copy,
// stall and reset priority with hand-computed expectations.
module tb_dstack;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  movement;
    logic [31:0] next_top;
    logic        rotate;
    logic [4:0]  rotate_addr;
    logic [31:0] top, second, third, rotate_value;
    logic [5:0]  depth;
    logic        empty, full, overflow, underflow;

    int tests  = 0;
    int failed = 0;

    dstack #(
        .WORD_WIDTH (32),
        .STACK_DEPTH(32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .movement    (movement),
        .next_top    (next_top),
        .rotate      (rotate),
        .rotate_addr (rotate_addr),
        .top         (top),
        .second      (second),
        .third       (third),
        .rotate_value(rotate_value),
        .depth       (depth),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one operation across a rising edge, then settle past the edge.
    task automatic op(input logic [1:0] mov, input logic [31:0] nt,
                      input logic rot, input logic [4:0] addr);
        movement    = mov;
        next_top    = nt;
        rotate      = rot;
        rotate_addr = addr;
        @(posedge clk);
        #1;
        stall  = 1'b0;
        reset  = 1'b0;
        rotate = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        op(2'b00, 32'h0, 1'b0, 5'd0);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; movement = 2'b00; next_top = '0;
        rotate = 1'b0; rotate_addr = 5'd0;
        #2;

        // Reset state
        do_reset();
        chk("rst_top", top, 0);
        chk("rst_second", second, 0);
        chk("rst_third", third, 0);
        chk("rst_rotval", rotate_value, 0);
        chk("rst_depth", depth, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);

        // Three pushes
        op(2'b01, 32'h11, 1'b0, 5'd0);
        chk("push1_empty", empty, 0);
        chk("push1_depth", depth, 1);
        op(2'b01, 32'h22, 1'b0, 5'd0);
        op(2'b01, 32'h33, 1'b0, 5'd0);
        chk("push3_top", top, 32'h33);
        chk("push3_second", second, 32'h22);
        chk("push3_third", third, 32'h11);
        chk("push3_depth", depth, 3);

        // Pop one, then pop two from depth 2 (underflow)
        op(2'b10, 32'h22, 1'b0, 5'd0);
        chk("pop1_top", top, 32'h22);
        chk("pop1_second", second, 32'h11);
        chk("pop1_depth", depth, 2);
        chk("pop1_udf", underflow, 0);
        op(2'b11, 32'h55, 1'b0, 5'd0);
        chk("pop2_top", top, 32'h55);
        chk("pop2_second", second, 0);
        chk("pop2_depth", depth, 1);
        chk("pop2_udf", underflow, 1);

        // Replace-top on an empty stack makes depth 1; pop one at depth 0 underflows
        do_reset();
        op(2'b00, 32'h42, 1'b0, 5'd0);
        chk("repl_top", top, 32'h42);
        chk("repl_depth", depth, 1);
        do_reset();
        op(2'b10, 32'h7, 1'b0, 5'd0);
        chk("pop_empty_depth", depth, 0);
        chk("pop_empty_udf", underflow, 1);

        // Fill to capacity, then overflow
        do_reset();
        for (int i = 1; i <= 32; i++) op(2'b01, 32'(i), 1'b0, 5'd0);
        chk("fill_depth", depth, 32);
        chk("fill_full", full, 1);
        chk("fill_ovf", overflow, 0);
        chk("fill_top", top, 32'd32);
        op(2'b01, 32'h99, 1'b0, 5'd0);
        chk("ovf_top", top, 32'h99);
        chk("ovf_second", second, 32'd32);
        chk("ovf_depth", depth, 32);
        chk("ovf_flag", overflow, 1);
        rotate_addr = 5'd31;
        #1;
        chk("ovf_bottom", rotate_value, 32'd2);

        // Rotate entry 3 to the top
        do_reset();
        op(2'b01, 32'hD, 1'b0, 5'd0);
        op(2'b01, 32'hC, 1'b0, 5'd0);
        op(2'b01, 32'hB, 1'b0, 5'd0);
        op(2'b01, 32'hA, 1'b0, 5'd0);
        rotate_addr = 5'd3;
        #1;
        chk("rot_read", rotate_value, 32'hD);
        op(2'b00, 32'hD, 1'b1, 5'd3);
        chk("rot_top", top, 32'hD);
        chk("rot_second", second, 32'hA);
        chk("rot_third", third, 32'hB);
        chk("rot_e3", rotate_value, 32'hC);
        chk("rot_depth", depth, 4);
        chk("rot_udf", underflow, 0);
        chk("rot_ovf", overflow, 0);
        // Rotate index equal to depth underflows, shift still happens
        op(2'b00, 32'h0, 1'b1, 5'd4);
        chk("rotbig_udf", underflow, 1);
        chk("rotbig_depth", depth, 4);
        chk("rotbig_second", second, 32'hD);
        chk("rotbig_e4", rotate_value, 32'hC);

        // Copy entry 2 onto the top via push
        do_reset();
        op(2'b01, 32'h7, 1'b0, 5'd0);
        op(2'b01, 32'h6, 1'b0, 5'd0);
        op(2'b01, 32'h5, 1'b0, 5'd0);
        rotate_addr = 5'd2;
        #1;
        chk("copy_read", rotate_value, 32'h7);
        op(2'b01, 32'h7, 1'b0, 5'd3);
        chk("copy_top", top, 32'h7);
        chk("copy_second", second, 32'h5);
        chk("copy_third", third, 32'h6);
        chk("copy_e3", rotate_value, 32'h7);
        chk("copy_depth", depth, 4);

        // Stall holds everything
        stall = 1'b1;
        op(2'b01, 32'hFF, 1'b0, 5'd3);
        chk("stall_top", top, 32'h7);
        chk("stall_second", second, 32'h5);
        chk("stall_depth", depth, 4);

        // Raise a fault, then reset coincident with a push clears it all
        op(2'b00, 32'h7, 1'b1, 5'd10);
        chk("pre_rst_udf", underflow, 1);
        reset = 1'b1;
        op(2'b01, 32'hAB, 1'b0, 5'd0);
        chk("rstpush_top", top, 0);
        chk("rstpush_second", second, 0);
        chk("rstpush_depth", depth, 0);
        chk("rstpush_empty", empty, 1);
        chk("rstpush_udf", underflow, 0);
        chk("rstpush_ovf", overflow, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
